pipe_skid_latch: RTL



---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/pipe_latch_if.sv | 17 +
 rtl/sat_counter.sv | 33 +++
 rtl/pipe_skid_latch.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and pipeline-latch occupancy state.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  // Encoding doubles as the entry count shown on the occupancy port.
  typedef enum logic [1:0] {
    PL_EMPTY = 2'd0,
    PL_ONE   = 2'd1,
    PL_TWO   = 2'd2
  } pl_state_t;

endpackage

// File: rtl/pipe_latch_if.sv
// Handshake bundle for one pipeline stage boundary.
interface pipe_latch_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport up    (output in_valid, output in_data, output flush, input in_ready);
  modport down  (input out_valid, input out_data, output out_ready);
  modport latch (input in_valid, input in_data, input flush, input out_ready,
                 output in_ready, output out_valid, output out_data);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: step by one while enabled, stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_latch.sv
// Pipeline stage latch with valid/ready handshake, flush, optional two-entry
// skid buffer and a saturating downstream-stall counter.
module pipe_skid_latch
  import cpu_types_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int NFIELDS = 2,
  parameter int SKID    = 1,
  parameter int CNT_W   = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NFIELDS*WORD_W-1:0]   in_data,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NFIELDS*WORD_W-1:0]   out_data,
  output logic [1:0]                  occupancy,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam int DATA_W = NFIELDS * WORD_W;

  pipe_latch_if #(.DATA_W(DATA_W)) hs ();

  assign hs.in_valid  = in_valid;
  assign hs.in_data   = in_data;
  assign hs.flush     = flush;
  assign hs.out_ready = out_ready;
  assign in_ready     = hs.in_ready;
  assign out_valid    = hs.out_valid;
  assign out_data     = hs.out_data;

  pl_state_t         state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire;
  logic              out_fire;
  logic              stall_en;

  assign hs.out_valid = (state_q != PL_EMPTY);
  assign hs.out_data  = main_q;
  assign occupancy    = 2'(state_q);

  assign in_fire  = hs.in_valid & hs.in_ready;
  assign out_fire = hs.out_valid & hs.out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;
      logic in_ready_d;

      // Upstream ready is registered so backpressure never propagates combinationally.
      always_comb begin
        in_ready_d = (state_d != PL_TWO);
      end

      // Ready register; accepting is the idle condition after reset.
      always_ff @(posedge CLK) begin
        if (RST) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= in_ready_d;
        end
      end

      assign hs.in_ready = in_ready_q;
    end else begin : g_noskid
      assign hs.in_ready = !hs.out_valid | hs.out_ready;
    end
  endgenerate

  // Occupancy state machine: flush empties, otherwise move entries main<-skid<-in.
  // Vacated registers are zeroed so an empty output always presents a NOP.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (hs.flush) begin
      state_d = PL_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        PL_EMPTY: begin
          if (in_fire) begin
            state_d = PL_ONE;
            main_d  = hs.in_data;
          end
        end
        PL_ONE: begin
          if (in_fire && out_fire) begin
            main_d = hs.in_data;
          end else if (in_fire) begin
            state_d = PL_TWO;
            skid_d  = hs.in_data;
          end else if (out_fire) begin
            state_d = PL_EMPTY;
            main_d  = '0;
          end
        end
        PL_TWO: begin
          if (out_fire) begin
            state_d = PL_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = PL_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // State and data registers; reset discards every held entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= PL_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign stall_en = hs.out_valid & !hs.out_ready & !hs.flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (CLK),
    .rst (RST),
    .en  (stall_en),
    .cnt (stall_cnt)
  );

endmodule
